// File: rtl/lcd_line_scaler_pkg.sv
// ============================================================================
// lcd_pkg : PPU mode encodings and raster total helper for lcd_line_scaler
// Rev 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;
    localparam logic [1:0] MODE_OAM    = 2'b10;
    localparam logic [1:0] MODE_XFER   = 2'b11;

    function automatic int calc_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_line_scaler_ram.sv
// ============================================================================
// lcd_line_ram : simple dual-port line-buffer RAM, NBUF lines of H pixels
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_line_ram #(
    parameter int DW   = 2,
    parameter int H    = 160,
    parameter int NBUF = 2,
    parameter int PW   = $clog2(H + 1),
    parameter int BW   = $clog2(NBUF)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [BW-1:0] wbuf,
    input  logic [PW-1:0] wptr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [BW-1:0] rbuf,
    input  logic [PW-1:0] rptr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = NBUF * H;
    localparam int AW    = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    // Lines are packed back to back so the array is exactly NBUF*H deep.
    assign w_waddr = AW'(wbuf) * AW'(H) + AW'(wptr);
    assign w_raddr = AW'(rbuf) * AW'(H) + AW'(rptr);

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[w_waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[w_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_line_scaler.sv
// ============================================================================
// lcd_line_scaler : LCD line capture ring with a free-running, PPU-resynced raster
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_line_scaler
    import lcd_pkg::*;
#(
    parameter int DW        = 2,
    parameter int H         = 160,
    parameter int HFP       = 24,
    parameter int HS        = 20,
    parameter int HBP       = 24,
    parameter int V         = 576,
    parameter int VFP       = 2,
    parameter int VS        = 2,
    parameter int VBP       = 36,
    parameter int NBUF      = 2,
    parameter int VSYNC_OFS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_en,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    mode,
    input  logic          out_en,
    input  logic          on,
    input  logic          clr_err,
    output logic          hs,
    output logic          vs,
    output logic          active,
    output logic [DW-1:0] dout,
    output logic          ovf,
    output logic          unf
);

    localparam int HTOT = calc_total(H, HFP, HS, HBP);
    localparam int VTOT = calc_total(V, VFP, VS, VBP);
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int PW   = $clog2(H + 1);
    localparam int BW   = $clog2(NBUF);

    localparam logic [HW-1:0] C_H_LAST   = HW'(HTOT - 1);
    localparam logic [HW-1:0] C_H_VIS    = HW'(H);
    localparam logic [HW-1:0] C_HS_ON    = HW'(H + HFP);
    localparam logic [HW-1:0] C_HS_OFF   = HW'(H + HFP + HS);
    localparam logic [VW-1:0] C_V_LAST   = VW'(VTOT - 1);
    localparam logic [VW-1:0] C_V_VIS    = VW'(V);
    localparam logic [VW-1:0] C_VS_ON    = VW'(V + VFP);
    localparam logic [VW-1:0] C_VS_OFF   = VW'(V + VFP + VS);
    localparam logic [VW-1:0] C_V_LOAD   = VW'(VTOT - VSYNC_OFS);
    localparam logic [PW-1:0] C_LINE_LEN = PW'(H);
    localparam logic [BW-1:0] C_RBUF_RST = BW'(NBUF - 1);

    logic [1:0]    r_last_mode;
    logic [PW-1:0] r_wptr;
    logic [BW-1:0] r_wbuf;
    logic [BW-1:0] r_done;
    logic          r_hreq;
    logic          r_vreq;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [BW-1:0] r_rbuf;
    logic [PW-1:0] r_rptr;
    logic          r_hs;
    logic          r_vs;
    logic          r_active;
    logic          r_show;
    logic          r_ovf;
    logic          r_unf;

    logic          w_wr_ok;
    logic          w_commit;
    logic          w_hedge;
    logic          w_vedge;
    logic          w_vis;
    logic          w_line_end;
    logic [VW-1:0] w_v_next;
    logic [DW-1:0] w_rdata;

    assign w_wr_ok    = in_en && (r_wptr < C_LINE_LEN);
    assign w_commit   = (r_last_mode == MODE_HBLANK) && (mode != MODE_HBLANK);
    assign w_hedge    = (r_last_mode == MODE_HBLANK) && (mode == MODE_OAM);
    assign w_vedge    = (r_last_mode == MODE_VBLANK) && (mode != MODE_VBLANK);
    assign w_vis      = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);
    assign w_line_end = (r_h_cnt == C_H_LAST);
    assign w_v_next   = r_vreq ? C_V_LOAD :
                        (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + VW'(1);

    // Write side, edge detection and sticky status run on every clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_mode <= MODE_HBLANK;
            r_wptr      <= '0;
            r_wbuf      <= '0;
            r_done      <= '0;
            r_hreq      <= 1'b0;
            r_vreq      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_last_mode <= mode;
            if (w_commit) begin
                r_wptr <= '0;
                r_wbuf <= r_wbuf + BW'(1);
                r_done <= r_wbuf;
            end else if (w_wr_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            // A vsync request is only acted on at a line boundary, so it waits for one.
            r_hreq <= w_hedge | (r_hreq & ~out_en);
            r_vreq <= w_vedge | (r_vreq & ~(out_en & w_line_end));
            r_ovf  <= (in_en & ~w_wr_ok) | (r_ovf & ~clr_err);
            r_unf  <= (out_en & w_vis & (r_rbuf == r_wbuf)) | (r_unf & ~clr_err);
        end
    end

    // Raster advances one pixel slot per out_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_rbuf   <= C_RBUF_RST;
            r_rptr   <= '0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b0;
            r_active <= 1'b0;
            r_show   <= 1'b0;
        end else if (out_en) begin
            r_h_cnt <= (r_hreq || w_line_end) ? '0 : r_h_cnt + HW'(1);
            if (r_h_cnt == C_HS_ON) begin
                r_hs <= 1'b0;
            end else if (r_h_cnt == C_HS_OFF) begin
                r_hs <= 1'b1;
            end
            if (w_line_end) begin
                r_v_cnt <= w_v_next;
                r_rbuf  <= r_done;
                if (w_v_next == C_VS_ON) begin
                    r_vs <= 1'b1;
                end else if (w_v_next == C_VS_OFF) begin
                    r_vs <= 1'b0;
                end
            end
            r_active <= w_vis;
            r_show   <= w_vis & on;
            r_rptr   <= (w_vis && !r_hreq) ? r_rptr + PW'(1) : '0;
        end
    end

    lcd_line_ram #(
        .DW   (DW),
        .H    (H),
        .NBUF (NBUF)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_ok),
        .wbuf  (r_wbuf),
        .wptr  (r_wptr),
        .wdata (in_data),
        .re    (out_en & w_vis),
        .rbuf  (r_rbuf),
        .rptr  (r_rptr),
        .rdata (w_rdata)
    );

    assign hs     = r_hs;
    assign vs     = r_vs;
    assign active = r_active;
    assign dout   = r_show ? w_rdata : '0;
    assign ovf    = r_ovf;
    assign unf    = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_lcd_line_scaler.sv
// ============================================================================
// tb_lcd_line_scaler : directed self-checking bench on a reduced raster (16x13)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_line_scaler;

    // Reduced geometry: HTOT = 8+2+3+3 = 16, VTOT = 6+1+2+4 = 13, vsync reload = 9
    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_en   = 1'b0;
    logic [1:0] in_data = 2'b00;
    logic [1:0] mode    = 2'b00;
    logic       out_en  = 1'b0;
    logic       on      = 1'b1;
    logic       clr_err = 1'b0;
    logic       hs, vs, active, ovf, unf;
    logic [1:0] dout;

    int vectors     = 0;
    int miscompares = 0;

    lcd_line_scaler #(
        .DW(2), .H(8), .HFP(2), .HS(3), .HBP(3),
        .V(6), .VFP(1), .VS(2), .VBP(4), .NBUF(2), .VSYNC_OFS(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_en   (in_en),
        .in_data (in_data),
        .mode    (mode),
        .out_en  (out_en),
        .on      (on),
        .clr_err (clr_err),
        .hs      (hs),
        .vs      (vs),
        .active  (active),
        .dout    (dout),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int   cnt_act, cnt_hsl, cnt_vs, fall1, fall2, vs_rise;
        logic prev_hs;
        cnt_act = 0; cnt_hsl = 0; cnt_vs = 0; fall1 = 0; fall2 = 0; vs_rise = 0;

        #1 reset_n = 1'b0;
        out_en = 1'b1;
        repeat (3) tick();
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        reset_n = 1'b1;

        // Free run, nothing written: raster shape and the missed-commit underrun
        prev_hs = hs;
        for (int n = 1; n <= 207; n++) begin
            tick();
            if (active) cnt_act++;
            if (!hs) cnt_hsl++;
            if (vs) begin
                cnt_vs++;
                if (vs_rise == 0) vs_rise = n;
            end
            if (!hs && prev_hs) begin
                if (fall1 == 0) fall1 = n;
                else if (fall2 == 0) fall2 = n;
            end
            prev_hs = hs;
            if (n == 16) chk("unf_first_line", 32'(unf), 32'd0);
        end
        chk("frame_active_slots", 32'(cnt_act), 32'd48);
        chk("frame_hs_low_slots", 32'(cnt_hsl), 32'd39);
        chk("frame_vs_high_slots", 32'(cnt_vs), 32'd32);
        chk("hs_first_fall", 32'(fall1), 32'd11);
        chk("hs_period", 32'(fall2 - fall1), 32'd16);
        chk("vs_first_rise", 32'(vs_rise), 32'd112);
        chk("unf_missed_commit", 32'(unf), 32'd1);

        out_en  = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("unf_cleared", 32'(unf), 32'd0);

        // Exactly H pixels i%4, then hblank->oam commit
        for (int i = 0; i < 8; i++) begin
            in_en   = 1'b1;
            in_data = 2'(i % 4);
            tick();
        end
        in_en = 1'b0;
        mode  = 2'b10;
        tick();
        chk("ovf_exact_h", 32'(ovf), 32'd0);
        out_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("lineA_active", 32'(active), 32'((k >= 2 && k <= 9) ? 1 : 0));
            chk("lineA_dout", 32'(dout), 32'((k >= 2 && k <= 9) ? (k - 2) % 4 : 0));
        end
        chk("unf_lineA", 32'(unf), 32'd0);

        // H+3 writes into the next line: overflow, first H pixels kept
        out_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            in_en   = 1'b1;
            in_data = (i < 8) ? 2'((7 - i) % 4) : 2'b01;
            tick();
        end
        in_en = 1'b0;
        chk("ovf_set", 32'(ovf), 32'd1);
        mode = 2'b00;
        tick();
        mode = 2'b10;
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        out_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k >= 2 && k <= 9) chk("lineB_dout", 32'(dout), 32'((9 - k) % 4));
        end

        // Display off: dout held at 0, active unchanged
        on = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("off_active", 32'(active), 32'((k >= 2) ? 1 : 0));
            chk("off_dout", 32'(dout), 32'd0);
        end

        // vblank exit mid-frame: v reloads to 9, four blank lines, no vsync
        out_en = 1'b0;
        on     = 1'b1;
        mode   = 2'b01;
        tick();
        mode = 2'b10;
        tick();
        out_en  = 1'b1;
        cnt_act = 0;
        cnt_vs  = 0;
        for (int j = 1; j <= 72; j++) begin
            tick();
            if (active) cnt_act++;
            if (vs) cnt_vs++;
        end
        chk("vresync_blank_active", 32'(cnt_act), 32'd0);
        chk("vresync_no_vs", 32'(cnt_vs), 32'd0);
        tick();
        chk("vresync_resume_active", 32'(active), 32'd1);
        chk("vresync_resume_dout", 32'(dout), 32'd3);

        // Asynchronous reset in the middle of a visible line
        tick();
        tick();
        chk("pre_reset_active", 32'(active), 32'd1);
        chk("pre_reset_dout", 32'(dout), 32'd1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_hs", 32'(hs), 32'd1);
        chk("async_rst_vs", 32'(vs), 32'd0);
        chk("async_rst_active", 32'(active), 32'd0);
        chk("async_rst_dout", 32'(dout), 32'd0);
        mode = 2'b00;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) begin
                chk("post_rst_active", 32'(active), 32'd1);
                chk("post_rst_dout_stale_buf", 32'(dout), 32'd3);
            end
            if (k == 10) chk("post_rst_hs_high", 32'(hs), 32'd1);
            if (k == 11) chk("post_rst_hs_fall", 32'(hs), 32'd0);
        end
        chk("post_rst_unf", 32'(unf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
